// File: rtl/control_sequencer_pkg.sv
// Shared constants for the ID-stage control sequencer: opcode/funct fields,
// control-signal bundles, ALU operations, multiply/divide ops and FSM states.
package control_sequencer_pkg;

   localparam logic [5:0] OPCODE_SPECIAL  = 6'h00;
   localparam logic [5:0] OPCODE_J        = 6'h02;
   localparam logic [5:0] OPCODE_JAL      = 6'h03;
   localparam logic [5:0] OPCODE_BEQ      = 6'h04;
   localparam logic [5:0] OPCODE_BNE      = 6'h05;
   localparam logic [5:0] OPCODE_ADDI     = 6'h08;
   localparam logic [5:0] OPCODE_ADDIU    = 6'h09;
   localparam logic [5:0] OPCODE_SLTI     = 6'h0A;
   localparam logic [5:0] OPCODE_SLTIU    = 6'h0B;
   localparam logic [5:0] OPCODE_SPECIAL2 = 6'h1C;
   localparam logic [5:0] OPCODE_LW       = 6'h23;
   localparam logic [5:0] OPCODE_SW       = 6'h2B;

   localparam logic [5:0] FUNCT_SLL   = 6'h00;
   localparam logic [5:0] FUNCT_SRL   = 6'h02;
   localparam logic [5:0] FUNCT_MUL   = 6'h02;
   localparam logic [5:0] FUNCT_JR    = 6'h08;
   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
   localparam logic [5:0] FUNCT_ADD   = 6'h20;
   localparam logic [5:0] FUNCT_ADDU  = 6'h21;
   localparam logic [5:0] FUNCT_SUB   = 6'h22;
   localparam logic [5:0] FUNCT_SUBU  = 6'h23;
   localparam logic [5:0] FUNCT_AND   = 6'h24;
   localparam logic [5:0] FUNCT_OR    = 6'h25;
   localparam logic [5:0] FUNCT_XOR   = 6'h26;
   localparam logic [5:0] FUNCT_NOR   = 6'h27;
   localparam logic [5:0] FUNCT_SLT   = 6'h2A;
   localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

   // {pc_src_hi, pc_src_lo, jump_link, alu_src, reg_dst, mem_read, mem_write, mem_to_reg, reg_write}
   localparam logic [8:0] SIG_NOP    = 9'h000;
   localparam logic [8:0] SIG_RTYPE  = 9'h011;
   localparam logic [8:0] SIG_ITYPE  = 9'h021;
   localparam logic [8:0] SIG_LW     = 9'h02B;
   localparam logic [8:0] SIG_SW     = 9'h024;
   localparam logic [8:0] SIG_BRANCH = 9'h100;
   localparam logic [8:0] SIG_J      = 9'h080;
   localparam logic [8:0] SIG_JAL    = 9'h0C1;
   localparam logic [8:0] SIG_JR     = 9'h180;

   localparam logic [4:0] ALUOP_ADD  = 5'd0;
   localparam logic [4:0] ALUOP_ADDU = 5'd1;
   localparam logic [4:0] ALUOP_SUB  = 5'd2;
   localparam logic [4:0] ALUOP_SUBU = 5'd3;
   localparam logic [4:0] ALUOP_AND  = 5'd4;
   localparam logic [4:0] ALUOP_OR   = 5'd5;
   localparam logic [4:0] ALUOP_XOR  = 5'd6;
   localparam logic [4:0] ALUOP_NOR  = 5'd7;
   localparam logic [4:0] ALUOP_SLT  = 5'd8;
   localparam logic [4:0] ALUOP_SLTU = 5'd9;
   localparam logic [4:0] ALUOP_SLL  = 5'd10;
   localparam logic [4:0] ALUOP_SRL  = 5'd11;
   localparam logic [4:0] ALUOP_MUL  = 5'd12;
   localparam logic [4:0] ALUOP_MFHI = 5'd13;
   localparam logic [4:0] ALUOP_MFLO = 5'd14;

   localparam logic [1:0] PCSEL_SEQ    = 2'b00;
   localparam logic [1:0] PCSEL_JUMP   = 2'b01;
   localparam logic [1:0] PCSEL_BRANCH = 2'b10;
   localparam logic [1:0] PCSEL_JR     = 2'b11;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   function automatic md_op_t md_op_of(input logic [5:0] funct);
      case (funct)
         FUNCT_MULTU: return MD_MULTU;
         FUNCT_DIV:   return MD_DIV;
         FUNCT_DIVU:  return MD_DIVU;
         default:     return MD_MULT;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// ID-stage bundle between the pipeline (master) and the control sequencer (slave).
interface control_sequencer_if;
   logic [5:0] id_opcode;
   logic [5:0] id_funct;
   logic       id_cmp_eq;
   logic       id_stall_ext;
   logic [8:0] id_signals;
   logic [4:0] id_alu_op;
   logic [1:0] id_pc_source_sel;
   logic       if_flush;
   logic       id_hold;
   logic       md_start;
   logic [1:0] md_op;
   logic       md_busy;
   logic       md_done;

   modport master (
      output id_opcode, id_funct, id_cmp_eq, id_stall_ext,
      input  id_signals, id_alu_op, id_pc_source_sel, if_flush, id_hold,
             md_start, md_op, md_busy, md_done
   );

   modport slave (
      input  id_opcode, id_funct, id_cmp_eq, id_stall_ext,
      output id_signals, id_alu_op, id_pc_source_sel, if_flush, id_hold,
             md_start, md_op, md_busy, md_done
   );
endinterface

// File: rtl/control_sequencer_md_sequencer.sv
// Multiply/divide latency tracker: loads a down-counter on start and flags
// busy/done with registered outputs until the terminal count is reached.
module md_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int MUL_LATENCY = 4,
   parameter int DIV_LATENCY = 32
) (
   input  logic clock,
   input  logic reset_n,
   input  logic start,
   input  logic is_div,
   output logic busy,
   output logic done
);
   // state   | meaning
   // MD_IDLE | no operation in flight, start accepted
   // MD_BUSY | counting down; done asserted while count == 0

   localparam logic [5:0] MUL_LOAD = 6'(MUL_LATENCY - 1);
   localparam logic [5:0] DIV_LOAD = 6'(DIV_LATENCY - 1);

   md_state_t  state;
   logic [5:0] count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= MD_IDLE;
         count <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start) begin
                  state <= MD_BUSY;
                  count <= is_div ? DIV_LOAD : MUL_LOAD;
                  busy  <= 1'b1;
               end
               done <= 1'b0;
            end
            MD_BUSY: begin
               if (count == '0) begin
                  state <= MD_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end else begin
                  count <= count - 6'd1;
                  done  <= (count == 6'd1);
               end
            end
            default: begin
               state <= MD_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// ID-stage control: combinational instruction decode, branch resolution and
// HI/LO interlock against the multiply/divide sequencer.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int MUL_LATENCY = 4,
   parameter int DIV_LATENCY = 32,
   parameter bit DELAY_SLOT  = 1'b1
) (
   input  logic                clock,
   input  logic                reset_n,
   control_sequencer_if.slave  bus
);
   logic [8:0] dec_sig;
   logic [4:0] dec_alu;
   logic [1:0] dec_pcs;
   logic       dec_md;
   logic       dec_hilo;
   md_op_t     md_kind;
   logic       md_busy;
   logic       md_done;
   logic       md_start;
   logic       hold;
   logic       suppress;

   always_comb begin
      dec_sig  = SIG_NOP;
      dec_alu  = ALUOP_ADDU;
      dec_pcs  = PCSEL_SEQ;
      dec_md   = 1'b0;
      dec_hilo = 1'b0;
      case (bus.id_opcode)
         OPCODE_SPECIAL: begin
            case (bus.id_funct)
               FUNCT_ADD:  begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_ADD;  end
               FUNCT_ADDU: begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_ADDU; end
               FUNCT_SUB:  begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_SUB;  end
               FUNCT_SUBU: begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_SUBU; end
               FUNCT_AND:  begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_AND;  end
               FUNCT_OR:   begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_OR;   end
               FUNCT_XOR:  begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_XOR;  end
               FUNCT_NOR:  begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_NOR;  end
               FUNCT_SLT:  begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_SLT;  end
               FUNCT_SLTU: begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_SLTU; end
               FUNCT_SLL:  begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_SLL;  end
               FUNCT_SRL:  begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_SRL;  end
               FUNCT_JR:   begin dec_sig = SIG_JR;    dec_pcs = PCSEL_JR;   end
               FUNCT_MFHI: begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_MFHI; dec_hilo = 1'b1; end
               FUNCT_MFLO: begin dec_sig = SIG_RTYPE; dec_alu = ALUOP_MFLO; dec_hilo = 1'b1; end
               FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: dec_md = 1'b1;
               default: ;
            endcase
         end
         OPCODE_SPECIAL2: begin
            if (bus.id_funct == FUNCT_MUL) begin
               dec_sig = SIG_RTYPE;
               dec_alu = ALUOP_MUL;
            end
         end
         OPCODE_J:     begin dec_sig = SIG_J;   dec_pcs = PCSEL_JUMP; end
         OPCODE_JAL:   begin dec_sig = SIG_JAL; dec_pcs = PCSEL_JUMP; end
         OPCODE_BEQ: begin
            dec_sig = SIG_BRANCH;
            dec_alu = ALUOP_SUBU;
            if (bus.id_cmp_eq) dec_pcs = PCSEL_BRANCH;
         end
         OPCODE_BNE: begin
            dec_sig = SIG_BRANCH;
            dec_alu = ALUOP_SUBU;
            if (!bus.id_cmp_eq) dec_pcs = PCSEL_BRANCH;
         end
         OPCODE_ADDI:  begin dec_sig = SIG_ITYPE; dec_alu = ALUOP_ADD;  end
         OPCODE_ADDIU: begin dec_sig = SIG_ITYPE; dec_alu = ALUOP_ADDU; end
         OPCODE_SLTI:  begin dec_sig = SIG_ITYPE; dec_alu = ALUOP_SLT;  end
         OPCODE_SLTIU: begin dec_sig = SIG_ITYPE; dec_alu = ALUOP_SLTU; end
         OPCODE_LW:    begin dec_sig = SIG_LW;    dec_alu = ALUOP_ADDU; end
         OPCODE_SW:    begin dec_sig = SIG_SW;    dec_alu = ALUOP_ADDU; end
         default: ;
      endcase
   end

   // Only HI/LO readers and new md ops must wait; everything else flows past a busy unit.
   assign hold     = md_busy && (dec_md || dec_hilo);
   assign suppress = hold || bus.id_stall_ext;
   assign md_kind  = md_op_of(bus.id_funct);
   assign md_start = reset_n && dec_md && !md_busy && !bus.id_stall_ext;

   md_sequencer #(
      .MUL_LATENCY (MUL_LATENCY),
      .DIV_LATENCY (DIV_LATENCY)
   ) u_md_sequencer (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (md_start),
      .is_div  ((md_kind == MD_DIV) || (md_kind == MD_DIVU)),
      .busy    (md_busy),
      .done    (md_done)
   );

   assign bus.id_signals       = suppress ? SIG_NOP    : dec_sig;
   assign bus.id_alu_op        = suppress ? ALUOP_ADDU : dec_alu;
   assign bus.id_pc_source_sel = suppress ? PCSEL_SEQ  : dec_pcs;
   assign bus.if_flush         = !DELAY_SLOT && !suppress && (dec_pcs != PCSEL_SEQ);
   assign bus.id_hold          = hold;
   assign bus.md_start         = md_start;
   assign bus.md_op            = md_kind;
   assign bus.md_busy          = md_busy;
   assign bus.md_done          = md_done;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a field-level decode model plus an md-latency
// model checked every cycle on two instances (delay slot on and off).
module tb_control_sequencer;
   import control_sequencer_pkg::*;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] opcode  = 6'h00;
   logic [5:0] funct   = 6'h00;
   logic       cmp_eq  = 1'b0;
   logic       stall   = 1'b0;
   bit         mon_en  = 1'b0;
   int         checks   = 0;
   int         failures = 0;
   int         md_left  = 0;   // busy cycles still to come, including the current one

   control_sequencer_if bus_ds ();
   control_sequencer_if bus_nd ();

   assign bus_ds.id_opcode = opcode;   assign bus_nd.id_opcode = opcode;
   assign bus_ds.id_funct = funct;     assign bus_nd.id_funct = funct;
   assign bus_ds.id_cmp_eq = cmp_eq;   assign bus_nd.id_cmp_eq = cmp_eq;
   assign bus_ds.id_stall_ext = stall; assign bus_nd.id_stall_ext = stall;

   control_sequencer #(.MUL_LATENCY(4), .DIV_LATENCY(32), .DELAY_SLOT(1'b1)) dut_ds (
      .clock(clock), .reset_n(reset_n), .bus(bus_ds));
   control_sequencer #(.MUL_LATENCY(4), .DIV_LATENCY(32), .DELAY_SLOT(1'b0)) dut_nd (
      .clock(clock), .reset_n(reset_n), .bus(bus_nd));

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected decode built from instruction semantics, field by field.
   function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                                      output logic [8:0] sig, output logic [4:0] alu,
                                      output logic [1:0] pcs, output logic md,
                                      output logic hilo, output logic div);
      logic rw, m2r, mw, mr, rd, asrc, link;
      logic [1:0] kind;
      {rw, m2r, mw, mr, rd, asrc, link} = '0;
      kind = 2'b00; alu = ALUOP_ADDU; pcs = 2'b00; md = 0; hilo = 0; div = 0;
      if (op == 6'h00) begin
         rd = 1; rw = 1;
         case (fn)
            6'h20: alu = ALUOP_ADD;   6'h21: alu = ALUOP_ADDU;
            6'h22: alu = ALUOP_SUB;   6'h23: alu = ALUOP_SUBU;
            6'h24: alu = ALUOP_AND;   6'h25: alu = ALUOP_OR;
            6'h26: alu = ALUOP_XOR;   6'h27: alu = ALUOP_NOR;
            6'h2A: alu = ALUOP_SLT;   6'h2B: alu = ALUOP_SLTU;
            6'h00: alu = ALUOP_SLL;   6'h02: alu = ALUOP_SRL;
            6'h10: begin alu = ALUOP_MFHI; hilo = 1; end
            6'h12: begin alu = ALUOP_MFLO; hilo = 1; end
            6'h08: begin rd = 0; rw = 0; kind = 2'b11; pcs = 2'b11; end
            6'h18, 6'h19: begin rd = 0; rw = 0; md = 1; end
            6'h1A, 6'h1B: begin rd = 0; rw = 0; md = 1; div = 1; end
            default: begin rd = 0; rw = 0; end
         endcase
      end else begin
         case (op)
            6'h1C: if (fn == 6'h02) begin rd = 1; rw = 1; alu = ALUOP_MUL; end
            6'h02: begin kind = 2'b01; pcs = 2'b01; end
            6'h03: begin kind = 2'b01; pcs = 2'b01; link = 1; rw = 1; end
            6'h04: begin kind = 2'b10; alu = ALUOP_SUBU; if (eq)  pcs = 2'b10; end
            6'h05: begin kind = 2'b10; alu = ALUOP_SUBU; if (!eq) pcs = 2'b10; end
            6'h08: begin asrc = 1; rw = 1; alu = ALUOP_ADD;  end
            6'h09: begin asrc = 1; rw = 1; alu = ALUOP_ADDU; end
            6'h0A: begin asrc = 1; rw = 1; alu = ALUOP_SLT;  end
            6'h0B: begin asrc = 1; rw = 1; alu = ALUOP_SLTU; end
            6'h23: begin asrc = 1; mr = 1; m2r = 1; rw = 1; end
            6'h2B: begin asrc = 1; mw = 1; end
            default: ;
         endcase
      end
      sig = {kind, link, asrc, rd, mr, mw, m2r, rw};
   endfunction

   logic [8:0] p_sig; logic [4:0] p_alu; logic [1:0] p_pcs; logic p_md, p_hilo, p_div;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) md_left <= 0;
      else begin
         ref_decode(opcode, funct, cmp_eq, p_sig, p_alu, p_pcs, p_md, p_hilo, p_div);
         if (md_left > 0) md_left <= md_left - 1;
         else if (p_md && !stall) md_left <= p_div ? 32 : 4;
      end
   end

   logic [8:0] c_sig; logic [4:0] c_alu; logic [1:0] c_pcs, c_op;
   logic c_md, c_hilo, c_div, c_busy, c_done, c_hold, c_start;
   always @(negedge clock) begin
      if (mon_en && reset_n) begin
         ref_decode(opcode, funct, cmp_eq, c_sig, c_alu, c_pcs, c_md, c_hilo, c_div);
         c_busy  = (md_left > 0);
         c_done  = (md_left == 1);
         c_hold  = c_busy && (c_md || c_hilo);
         c_start = c_md && !c_busy && !stall;
         c_op    = 2'(funct - 6'h18);
         if (c_hold || stall) begin c_sig = '0; c_alu = ALUOP_ADDU; c_pcs = 2'b00; end
         check("m_sig",   bus_ds.id_signals, c_sig);
         check("m_alu",   bus_ds.id_alu_op, c_alu);
         check("m_pcs",   bus_ds.id_pc_source_sel, c_pcs);
         check("m_hold",  bus_ds.id_hold, c_hold);
         check("m_start", bus_ds.md_start, c_start);
         check("m_busy",  bus_ds.md_busy, c_busy);
         check("m_done",  bus_ds.md_done, c_done);
         check("m_flush_ds", bus_ds.if_flush, 1'b0);
         check("m_flush_nd", bus_nd.if_flush, c_pcs != 2'b00);
         check("m_sig_nd",   bus_nd.id_signals, c_sig);
         check("m_hold_nd",  bus_nd.id_hold, c_hold);
         if (c_start) check("m_md_op", bus_ds.md_op, c_op);
      end
   end

   task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic eq, input logic st);
      opcode = op; funct = fn; cmp_eq = eq; stall = st;
      #2;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   localparam logic [11:0] SWEEP [0:29] = '{
      12'h020, 12'h021, 12'h022, 12'h023, 12'h024, 12'h025, 12'h026, 12'h027,
      12'h02A, 12'h02B, 12'h000, 12'h002, 12'h008, 12'h010, 12'h012, 12'h702,
      12'h080, 12'h0C0, 12'h100, 12'h140, 12'h200, 12'h240, 12'h280, 12'h2C0,
      12'h8C0, 12'hAC0, 12'hFC0, 12'h03F, 12'h700, 12'h3C0 };

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_n, done_at, held;
      logic done_last, released, done_seen;
      logic [11:0] v;

      // reset: md outputs forced low, decode still live
      tick();
      apply(6'h00, 6'h18, 0, 0);
      check("rst_start", bus_ds.md_start, 1'b0);
      check("rst_busy",  bus_ds.md_busy, 1'b0);
      check("rst_done",  bus_ds.md_done, 1'b0);
      check("rst_hold",  bus_ds.id_hold, 1'b0);
      apply(6'h23, 6'h00, 0, 0);
      check("rst_lw_sig", bus_ds.id_signals, 9'h02B);
      apply(6'h00, 6'h00, 0, 0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      tick();

      foreach (SWEEP[i]) begin
         for (int e = 0; e < 2; e++) begin
            for (int s = 0; s < 2; s++) begin
               v = SWEEP[i];
               apply(v[11:6], v[5:0], e[0], s[0]);
               tick();
            end
         end
      end

      apply(6'h23, 6'h00, 0, 0); check("lw_sig", bus_ds.id_signals, 9'h02B); tick();
      apply(6'h2B, 6'h00, 0, 0); check("sw_sig", bus_ds.id_signals, 9'h024); tick();
      apply(6'h04, 6'h00, 1, 0);
      check("beq_t_pcs", bus_ds.id_pc_source_sel, 2'b10);
      check("beq_t_flush_ds", bus_ds.if_flush, 1'b0);
      check("beq_t_flush_nd", bus_nd.if_flush, 1'b1);
      tick();
      apply(6'h04, 6'h00, 0, 0);
      check("beq_nt_pcs", bus_ds.id_pc_source_sel, 2'b00);
      check("beq_nt_flush_nd", bus_nd.if_flush, 1'b0);
      tick();
      apply(6'h05, 6'h00, 0, 0); check("bne_t_pcs", bus_ds.id_pc_source_sel, 2'b10); tick();
      apply(6'h02, 6'h00, 0, 0);
      check("j_pcs", bus_ds.id_pc_source_sel, 2'b01);
      check("j_flush_nd", bus_nd.if_flush, 1'b1);
      tick();
      apply(6'h00, 6'h08, 0, 0); check("jr_pcs", bus_ds.id_pc_source_sel, 2'b11); tick();
      apply(6'h04, 6'h00, 1, 1);
      check("stall_sig", bus_ds.id_signals, 9'h000);
      check("stall_flush_nd", bus_nd.if_flush, 1'b0);
      tick();
      apply(6'h00, 6'h10, 0, 0); check("mfhi_idle_hold", bus_ds.id_hold, 1'b0); tick();

      // MULT with independent ADDU behind it
      apply(6'h00, 6'h18, 0, 0);
      check("mult_start", bus_ds.md_start, 1'b1);
      check("mult_op", bus_ds.md_op, 2'b00);
      tick();
      busy_n = 0; done_at = -1;
      for (int c = 1; c <= 8; c++) begin
         apply(6'h00, 6'h21, 0, 0);
         check("addu_hold", bus_ds.id_hold, 1'b0);
         if (c == 1) check("addu_sig", bus_ds.id_signals, 9'h011);
         if (c == 5) check("mult_idle_c5", bus_ds.md_busy, 1'b0);
         if (bus_ds.md_busy) busy_n++;
         if (bus_ds.md_done) done_at = c;
         tick();
      end
      check("mult_busy_cycles", busy_n, 4);
      check("mult_done_cycle", done_at, 4);

      // DIV then MFLO interlock
      apply(6'h00, 6'h1A, 0, 0);
      check("div_start", bus_ds.md_start, 1'b1);
      check("div_op", bus_ds.md_op, 2'b10);
      tick();
      held = 0; done_last = 0; released = 0;
      for (int c = 0; c < 100; c++) begin
         apply(6'h00, 6'h12, 0, 0);
         if (bus_ds.id_hold) begin
            held++;
            done_last = bus_ds.md_done;
            tick();
         end else begin
            released = 1;
            break;
         end
      end
      check("mflo_released", released, 1'b1);
      check("mflo_hold_cycles", held, 32);
      check("mflo_hold_on_done", done_last, 1'b1);
      check("mflo_issue_sig", bus_ds.id_signals, 9'h011);
      check("mflo_issue_alu", bus_ds.id_alu_op, ALUOP_MFLO);
      tick();

      // reset while DIVU count is 10
      apply(6'h00, 6'h1B, 0, 0);
      tick();
      for (int c = 0; c < 21; c++) begin
         apply(6'h00, 6'h00, 0, 0);
         tick();
      end
      apply(6'h00, 6'h00, 0, 0);
      check("pre_rst_busy", bus_ds.md_busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy", bus_ds.md_busy, 1'b0);
      check("mid_rst_done", bus_ds.md_done, 1'b0);
      apply(6'h00, 6'h18, 0, 0);
      check("mid_rst_start", bus_ds.md_start, 1'b0);
      apply(6'h00, 6'h00, 0, 0);
      tick();
      tick();
      reset_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         apply(6'h00, 6'h00, 0, 0);
         if (bus_ds.md_done || bus_ds.md_busy) done_seen = 1;
         tick();
      end
      check("no_done_after_rst", done_seen, 1'b0);
      apply(6'h00, 6'h18, 0, 0);
      check("mult_after_rst_start", bus_ds.md_start, 1'b1);
      tick();
      busy_n = 0;
      for (int c = 0; c < 6; c++) begin
         apply(6'h00, 6'h00, 0, 0);
         if (bus_ds.md_busy) busy_n++;
         tick();
      end
      check("mult_after_rst_busy", busy_n, 4);

      // MULT held off by external stall
      for (int c = 0; c < 3; c++) begin
         apply(6'h00, 6'h19, 0, 1);
         check("stall_mult_start", bus_ds.md_start, 1'b0);
         check("stall_mult_idle", bus_ds.md_busy, 1'b0);
         tick();
      end
      apply(6'h00, 6'h19, 0, 0);
      check("unstall_start", bus_ds.md_start, 1'b1);
      check("unstall_op", bus_ds.md_op, 2'b01);
      tick();
      apply(6'h00, 6'h21, 0, 1); tick();
      apply(6'h00, 6'h1B, 0, 0); tick();
      apply(6'h00, 6'h10, 0, 0); tick();
      for (int c = 0; c < 40; c++) begin
         apply(6'h00, 6'h10, 0, 0);
         tick();
      end

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter MUL_LATENCY, default 4, cycles from MULT/MULTU start to HI/LO result (legal 2..64).
REQ-002 Parameter DIV_LATENCY, default 32, cycles from DIV/DIVU start to HI/LO result (legal 2..64).
REQ-003 Parameter DELAY_SLOT, default 1; 1 = architectural branch delay slot, 0 = flush IF on taken branch/jump.
REQ-004 clock  in  1  single system clock, rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 id_opcode  in  6  opcode of the instruction in ID.
REQ-007 id_funct  in  6  funct field of the instruction in ID.
REQ-008 id_cmp_eq  in  1  rs==rt comparator result from ID.
REQ-009 id_stall_ext  in  1  load-use/forwarding stall from the hazard unit.
REQ-010 id_signals  out  9  {pc_src_hi, pc_src_lo, jump_link, alu_src, reg_dst, mem_read, mem_write, mem_to_reg, reg_write}, shared SIG_* encoding.
REQ-011 id_alu_op  out  5  ALU operation, shared ALUOP_* encoding.
REQ-012 id_pc_source_sel  out  2  00 PC+4, 01 jump, 10 branch, 11 jump register.
REQ-013 if_flush  out  1  squash the instruction in IF.
REQ-014 id_hold  out  1  freeze PC and IF/ID, bubble into EX.
REQ-015 md_start  out  1  one-cycle start pulse to the multiply/divide unit.
REQ-016 md_op  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; valid with md_start.
REQ-017 md_busy  out  1  multiply/divide operation in flight.
REQ-018 md_done  out  1  one-cycle pulse; HI/LO written this cycle.

Function
REQ-019 Decode SHALL be combinational and cover ADD, ADDU, AND, JR, NOR, OR, SLL, SLT, SLTU, SRL, SUB, SUBU, XOR, MUL, MULT, MULTU, DIV, DIVU, MFHI, MFLO, ADDI, ADDIU, SLTI, SLTIU, J, JAL, BEQ, BNE, LW, SW; any other encoding decodes to SIG_NOP with ALUOP_ADDU.
REQ-020 When id_stall_ext or id_hold is 1, id_signals SHALL be SIG_NOP, id_alu_op ALUOP_ADDU, md_start 0, if_flush 0.
REQ-021 BEQ taken iff id_cmp_eq=1; BNE taken iff id_cmp_eq=0; untaken branch gives id_pc_source_sel=00.
REQ-022 if_flush SHALL equal 0 when DELAY_SLOT=1; when DELAY_SLOT=0 it SHALL be 1 for a taken branch, J, JAL or JR.
REQ-023 FSM states IDLE and BUSY; IDLE->BUSY on md_start; BUSY->IDLE on the edge after count==0.
REQ-024 On md_start a 6-bit down-counter SHALL load MUL_LATENCY-1 (MULT/MULTU) or DIV_LATENCY-1 (DIV/DIVU) and decrement each cycle in BUSY.
REQ-025 md_busy SHALL equal (state==BUSY); md_done SHALL be 1 exactly in the BUSY cycle with count==0.
REQ-026 md_start SHALL be 1 when ID holds MULT/MULTU/DIV/DIVU, state is IDLE, id_stall_ext=0.
REQ-027 id_hold SHALL be 1 while state==BUSY and ID holds MFHI, MFLO, MULT, MULTU, DIV or DIVU, including the md_done cycle; released the following cycle.
REQ-028 Independent instructions SHALL issue without hold while BUSY.
REQ-029 MFHI/MFLO decoded in IDLE SHALL issue with no hold.

Reset
REQ-030 Assertion of reset_n SHALL immediately force state IDLE, count 0, md_busy 0, md_done 0, md_start 0, id_hold 0; an in-flight operation is abandoned with no md_done.
REQ-031 Combinational decode outputs SHALL depend only on inputs, never on reset.

Structure
REQ-032 OPCODE_*, FUNCT_*, SIG_*, ALUOP_*, md_op encodings and FSM state encoding SHALL live in the shared constants package.
REQ-033 Counter and FSM SHALL form one sub-module, md_sequencer; decode stays at top level.

Verification
REQ-034 MULT (op 0x00, funct 0x18) in IDLE -> md_start=1, md_op=00; md_busy cycles 1..4; md_done in cycle 4; IDLE in cycle 5.
REQ-035 DIV (funct 0x1A) then MFLO (funct 0x12) next cycle -> id_hold=1 for 32 cycles, MFLO issues cycle after md_done, no extra stall.
REQ-036 MULT then ADDU (funct 0x21) during BUSY -> id_hold=0, ADDU signals issued.
REQ-037 BEQ (0x04), id_cmp_eq=1 -> pc_source_sel=10; if_flush 0 with DELAY_SLOT=1, 1 with DELAY_SLOT=0; id_cmp_eq=0 -> 00, no flush.
REQ-038 reset_n low during DIV count=10 -> md_busy=0 immediately, no md_done; next MULT starts normally.
REQ-039 MULT with id_stall_ext=1 -> md_start=0, state IDLE; start on first cycle stall drops.
